// File: rtl/gf2m_mul_serial_if.sv
`default_nettype none
// ============================================================================
//  Module   : gf2m_mul_serial_if
//  Purpose  : Request/result bundle between the operand selectors and the
//             bit-serial GF(2^m) multiplier.
//  Revision : 1.0  initial release
// ============================================================================
interface gf2m_mul_serial_if #(
  parameter int N = 233
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] z;

  modport master (
    output start, a, b,
    input  busy, done, z
  );

  modport slave (
    input  start, a, b,
    output busy, done, z
  );
endinterface
`default_nettype wire

// File: rtl/gf2m_mul_serial.sv
`default_nettype none
// ============================================================================
//  Module   : gf2m_mul_serial
//  Purpose  : MSB-first bit-serial multiplier over GF(2^N), polynomial basis,
//             reduced modulo the trinomial x^N + x^TAP + 1.
//  Revision : 1.0  initial release
// ============================================================================
module gf2m_mul_serial #(
  parameter int N   = 233,
  parameter int TAP = 74
) (
  input  wire                      clk,
  input  wire                      rst_n,
  gf2m_mul_serial_if.slave         bus
);

  localparam int CW = $clog2(N);

  localparam logic [CW-1:0] c_cnt_init = CW'(N - 1);
  localparam logic [CW-1:0] c_cnt_zero = '0;
  localparam logic [N-1:0]  c_red      = (N'(1) << TAP) | N'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_z;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;

  logic [N-1:0]   w_a_nxt;
  logic [N-1:0]   w_b_nxt;
  logic [N-1:0]   w_z_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [N-1:0]   w_z_xtime;
  logic [N-1:0]   w_z_step;

  // Multiply-by-x with the single fold needed for a trinomial modulus.
  always_comb begin
    w_z_xtime = {r_z[N-2:0], 1'b0};
    if (r_z[N-1]) begin
      w_z_xtime = w_z_xtime ^ c_red;
    end
    w_z_step = w_z_xtime;
    if (r_b[r_cnt]) begin
      w_z_step = w_z_xtime ^ r_a;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_z_nxt     = r_z;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_nxt     = bus.a;
          w_b_nxt     = bus.b;
          w_z_nxt     = '0;
          w_cnt_nxt   = c_cnt_init;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_z_nxt = w_z_step;
        // The counter parks at zero rather than wrapping on the last bit.
        if (r_cnt == c_cnt_zero) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_z     <= w_z_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.z    = r_z;

endmodule
`default_nettype wire

// File: tb/tb_gf2m_mul_serial.sv
`default_nettype none
// Directed and randomized checks of the GF(2^233) bit-serial multiplier
// against an independent LSB-first software field model.
module tb_gf2m_mul_serial;
  localparam int N   = 233;
  localparam int TAP = 74;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  gf2m_mul_serial_if #(.N(N)) bus ();

  gf2m_mul_serial #(.N(N), .TAP(TAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] z;
    string        name;
  } vec_t;

  function automatic logic [N-1:0] bitv(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference: LSB-first shift-and-add, reducing the multiplicand each step.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r;
    logic [N-1:0] t;
    logic         c;
    r = '0;
    t = a;
    for (int i = 0; i < N; i++) begin
      if (b[i]) r = r ^ t;
      c = t[N-1];
      t = t << 1;
      if (c) begin
        t[TAP] = ~t[TAP];
        t[0]   = ~t[0];
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rand_n();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w[N-1:0];
  endfunction

  task automatic check_z(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One START pulse; checks the DONE position and the BUSY window.
  task automatic run_mul(input logic [N-1:0] ia, input logic [N-1:0] ib,
                         output logic [N-1:0] oz);
    int dk;
    int prof_err;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    tick();
    bus.start = 1'b0;
    bus.a     = ~ia;
    bus.b     = ib ^ {N{1'b1}};
    dk        = -1;
    prof_err  = 0;
    oz        = '0;
    for (int k = 0; k <= N + 1; k++) begin
      if (k > 0) tick();
      if (bus.done === 1'b1) begin
        if (dk < 0) dk = k;
        else prof_err++;
      end
      if (bus.busy !== (k <= N)) prof_err++;
      if (k == N) oz = bus.z;
    end
    check_int("done_latency", dk, N);
    check_int("busy_profile_errors", prof_err, 0);
  endtask

  vec_t         vecs[6];
  logic [N-1:0] z1;
  logic [N-1:0] z2;
  logic [N-1:0] ra;
  logic [N-1:0] rb;
  logic [N-1:0] exp_dbl;
  int           dones;
  int           idle_err;

  initial begin
    n_cmp = 0;
    n_err = 0;

    exp_dbl = bitv(231) | bitv(146) | bitv(72);
    vecs[0] = '{a: bitv(0),   b: bitv(0),     z: bitv(0),               name: "one_x_one"};
    vecs[1] = '{a: bitv(1),   b: bitv(232),   z: bitv(74) | bitv(0),    name: "x_x232"};
    vecs[2] = '{a: bitv(232), b: bitv(232),   z: exp_dbl,               name: "x232_sq"};
    vecs[3] = '{a: '0,        b: {N{1'b1}},   z: '0,                    name: "zero_ones"};
    vecs[4] = '{a: bitv(100), b: bitv(50),    z: bitv(150),             name: "x100_x50"};
    vecs[5] = '{a: bitv(200), b: bitv(40),    z: bitv(81) | bitv(7),    name: "x200_x40"};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_busy", int'(bus.busy), 0);
    check_int("reset_done", int'(bus.done), 0);
    check_z("reset_z", bus.z, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_int("idle_busy", int'(bus.busy), 0);

    for (int i = 0; i < 6; i++) begin
      run_mul(vecs[i].a, vecs[i].b, z1);
      check_z(vecs[i].name, z1, vecs[i].z);
    end

    // Product must hold through idle cycles.
    repeat (5) tick();
    check_z("z_hold_idle", bus.z, vecs[5].z);

    // START pulses in cycles 5, 100 and 234 (the DONE cycle) with new operands.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = bitv(232);
    bus.b     = bitv(232);
    tick();
    bus.start = 1'b0;
    dones     = 0;
    idle_err  = 0;
    for (int k = 0; k <= N + 6; k++) begin
      if (k > 0) tick();
      bus.start = 1'b0;
      if (bus.done === 1'b1) dones++;
      if (k == N) check_z("midstart_product", bus.z, exp_dbl);
      if (k > N && bus.busy !== 1'b0) idle_err++;
      if (k == 4 || k == 99 || k == N) begin
        bus.start = 1'b1;
        bus.a     = rand_n();
        bus.b     = rand_n();
      end
    end
    bus.start = 1'b0;
    check_int("midstart_done_count", dones, 1);
    check_int("midstart_no_restart", idle_err, 0);
    check_z("midstart_z_hold", bus.z, exp_dbl);

    // Asynchronous reset in cycle 120 of a running multiply.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = bitv(5);
    bus.b     = {N{1'b1}};
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 120; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_int("async_rst_busy", int'(bus.busy), 0);
    check_int("async_rst_done", int'(bus.done), 0);
    check_z("async_rst_z", bus.z, '0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    check_int("post_rst_quiet", dones, 0);
    run_mul(bitv(1), bitv(232), z1);
    check_z("post_rst_mul", z1, bitv(74) | bitv(0));

    for (int i = 0; i < 40; i++) begin
      ra = rand_n();
      rb = rand_n();
      run_mul(ra, rb, z1);
      run_mul(rb, ra, z2);
      check_z("rand_model", z1, gf_mul(ra, rb));
      check_z("rand_swap", z2, z1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
